// File: rtl/period_meter.sv
// rtl/period_meter.sv - period of sig_in in clk cycles, reported as a divider value
// Optional four-period averaging is compiled in with `define PERIOD_METER_AVG_EN.
module period_meter #(
  parameter int WIDTH       = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;
  logic                   rise;
  logic                   done;
  logic                   tmo_evt;

`ifdef PERIOD_METER_AVG_EN
  logic [WIDTH+1:0]       acc_q, acc_d;
  logic [1:0]             acc_n_q, acc_n_d;
  logic [WIDTH+1:0]       sum;
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign hist_d = sync_q[SYNC_STAGES-1];
  assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    tmo_evt = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // A rise on the saturating cycle still counts as a valid period.
          if (rise) begin
            done  = 1'b1;
            cnt_d = {{(WIDTH-1){1'b0}}, 1'b1};
          end else if (cnt_q == CNT_MAX) begin
            tmo_evt = 1'b1;
            cnt_d   = '0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    period_d = period_q;
    valid_d  = 1'b0;
`ifdef PERIOD_METER_AVG_EN
    acc_d   = acc_q;
    acc_n_d = acc_n_q;
    sum     = acc_q + {2'b00, cnt_q};
    if (!enable || tmo_evt) begin
      acc_d   = '0;
      acc_n_d = 2'd0;
    end else if (done) begin
      if (acc_n_q == 2'd3) begin
        period_d = sum[WIDTH+1:2];
        valid_d  = 1'b1;
        acc_d    = '0;
        acc_n_d  = 2'd0;
      end else begin
        acc_d   = sum;
        acc_n_d = acc_n_q + 2'd1;
      end
    end
`else
    if (done) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
    end
`endif
    if (!enable || valid_d) begin
      timeout_d = 1'b0;
    end else if (tmo_evt) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      acc_q     <= '0;
      acc_n_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
`ifdef PERIOD_METER_AVG_EN
      acc_q     <= acc_d;
      acc_n_q   <= acc_n_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule
